// File: rtl/mac_issue_collect.sv
// Issue/collect controller for the 2-stage FP32/FP16 MAC: credit-gated operand issue,
// a tag pipe matched to MAC latency, an in-order result FIFO and sticky exception flags.
module mac_issue_collect #(
   parameter int MAC_LAT   = 3,
   parameter int RES_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_fp_mode,
   input  logic [2:0]  in_rm,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [31:0] in_c,
   output logic [1:0]  mac_fp_mode_o,
   output logic [2:0]  mac_rm_o,
   output logic [15:0] mac_a16_o,
   output logic [15:0] mac_b16_o,
   output logic [15:0] mac_c16_o,
   output logic [31:0] mac_a32_o,
   output logic [31:0] mac_b32_o,
   output logic [31:0] mac_c32_o,
   input  logic [31:0] mac_r32_i,
   input  logic [4:0]  mac_flags_i,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_flags,
   output logic [1:0]  out_mode,
   output logic [4:0]  flags_sticky_o,
   input  logic        flags_clr_i,
   output logic        busy_o
);

   localparam int PW   = $clog2(RES_DEPTH);
   localparam int CW   = $clog2(RES_DEPTH + MAC_LAT + 1);
   localparam int LAST = MAC_LAT - 1;
   localparam int EW   = 39;

   logic [MAC_LAT-1:0] tagValid_q, tagValid_d;
   logic [MAC_LAT-1:0] tagIllegal_q, tagIllegal_d;
   logic [1:0]         tagMode_q [MAC_LAT];
   logic [1:0]         tagMode_d [MAC_LAT];

   logic [EW-1:0]      fifoMem_q [RES_DEPTH];
   logic [PW-1:0]      rdPtr_q, rdPtr_d;
   logic [PW-1:0]      wrPtr_q, wrPtr_d;
   logic [PW:0]        fifoCnt_q, fifoCnt_d;
   logic [4:0]         sticky_q, sticky_d;

   logic [CW-1:0]      inflightCnt;
   logic [CW-1:0]      creditUsed;
   logic               issue;
   logic               push;
   logic               pop;
   logic               fifoEmpty;
   logic [31:0]        capResult;
   logic [4:0]         capFlags;
   logic [EW-1:0]      headEntry;

   // Round-to-nearest-even narrowing; NaNs collapse to the canonical quiet NaN.
   function automatic logic [15:0] fp32ToFp16(input logic [31:0] x);
      logic              sgn;
      logic [7:0]        expo;
      logic [22:0]       man;
      logic signed [9:0] e16;
      logic [3:0]        shAmt;
      logic [33:0]       shifted;
      logic              roundUp;
      logic [15:0]       res;
      sgn     = x[31];
      expo    = x[30:23];
      man     = x[22:0];
      e16     = $signed({2'b00, expo}) - 10'sd112;
      shAmt   = '0;
      shifted = '0;
      roundUp = 1'b0;
      res     = {sgn, 15'h0};
      if (expo == 8'hFF) begin
         res = (man != '0) ? 16'h7E00 : {sgn, 15'h7C00};
      end else if (expo == 8'h00) begin
         res = {sgn, 15'h0};
      end else if (e16 >= 10'sd31) begin
         res = {sgn, 15'h7C00};
      end else if (e16 >= 10'sd1) begin
         roundUp = man[12] && ((|man[11:0]) || man[13]);
         res     = {sgn, e16[4:0], man[22:13]} + {15'h0, roundUp};
      end else if (e16 >= -10'sd10) begin
         // Subnormal result: align the significand to the 2^-24 grid before rounding.
         shAmt   = 4'(-e16);
         shifted = {1'b1, man, 10'h0} >> shAmt;
         roundUp = shifted[23] && ((|shifted[22:0]) || shifted[24]);
         res     = {sgn, 5'h0, shifted[33:24]} + {15'h0, roundUp};
      end
      return res;
   endfunction

   always_comb begin
      inflightCnt = '0;
      for (int i = 0; i < MAC_LAT; i++) begin
         inflightCnt = inflightCnt + CW'(tagValid_q[i]);
      end
   end

   // Credit counts every op that will eventually need a FIFO slot; pops free it next cycle.
   assign creditUsed = inflightCnt + CW'(fifoCnt_q);
   assign in_ready   = !rst && (creditUsed < CW'(RES_DEPTH));
   assign issue      = in_valid && in_ready;

   assign mac_fp_mode_o = in_fp_mode;
   assign mac_rm_o      = in_rm;
   assign mac_a16_o     = in_a[15:0];
   assign mac_b16_o     = in_b[15:0];
   assign mac_c16_o     = in_c[15:0];
   assign mac_a32_o     = in_a;
   assign mac_b32_o     = in_b;
   assign mac_c32_o     = in_c;

   assign fifoEmpty = (fifoCnt_q == '0);
   assign push      = tagValid_q[LAST];
   assign pop       = !fifoEmpty && out_ready;

   always_comb begin
      capResult = mac_r32_i;
      capFlags  = mac_flags_i;
      if (tagIllegal_q[LAST]) begin
         capResult = 32'h7FC0_0000;
         capFlags  = 5'b10000;
      end else if (tagMode_q[LAST] == 2'b01) begin
         capResult = {16'h0, fp32ToFp16(mac_r32_i)};
      end
   end

   always_comb begin
      tagValid_d[0]   = issue;
      tagMode_d[0]    = in_fp_mode;
      tagIllegal_d[0] = (in_fp_mode == 2'b11);
      for (int i = 1; i < MAC_LAT; i++) begin
         tagValid_d[i]   = tagValid_q[i-1];
         tagMode_d[i]    = tagMode_q[i-1];
         tagIllegal_d[i] = tagIllegal_q[i-1];
      end
      wrPtr_d   = wrPtr_q + PW'(push);
      rdPtr_d   = rdPtr_q + PW'(pop);
      fifoCnt_d = fifoCnt_q + (PW+1)'(push) - (PW+1)'(pop);
      // A clear coinciding with a capture leaves only the new flags.
      sticky_d  = flags_clr_i ? 5'b0 : sticky_q;
      if (push) begin
         sticky_d = sticky_d | capFlags;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tagValid_q   <= '0;
         tagIllegal_q <= '0;
         for (int i = 0; i < MAC_LAT; i++) begin
            tagMode_q[i] <= '0;
         end
         rdPtr_q   <= '0;
         wrPtr_q   <= '0;
         fifoCnt_q <= '0;
         sticky_q  <= '0;
      end else begin
         tagValid_q   <= tagValid_d;
         tagIllegal_q <= tagIllegal_d;
         for (int i = 0; i < MAC_LAT; i++) begin
            tagMode_q[i] <= tagMode_d[i];
         end
         rdPtr_q   <= rdPtr_d;
         wrPtr_q   <= wrPtr_d;
         fifoCnt_q <= fifoCnt_d;
         sticky_q  <= sticky_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem_q[wrPtr_q] <= {capResult, capFlags, tagMode_q[LAST]};
      end
   end

   assign headEntry = fifoMem_q[rdPtr_q];
   assign out_valid = !fifoEmpty;
   assign {out_result, out_flags, out_mode} = fifoEmpty ? '0 : headEntry;
   assign flags_sticky_o = sticky_q;
   assign busy_o         = (inflightCnt != '0) || !fifoEmpty;

endmodule

// File: doc/mac_issue_collect.md
Name: mac_issue_collect

Overview:
- Front-end/back-end controller for the 2-stage FP32/FP16 MAC pipeline. It is the producer of MAC operands and the consumer of MAC results.
- Accepts operand triples over a valid/ready interface and drives them into the MAC one per cycle.
- Tracks in-flight operations with a tag pipeline matched to MAC latency, then captures results into a result FIFO with valid/ready output.
- Credit-gates issue because the MAC cannot stall. Accumulates sticky exception flags.

Parameters:
- MAC_LAT, 3, clock edges from the issue edge to the capture edge of that op's result on mac_r32_i/mac_flags_i.
- RES_DEPTH, 8, result FIFO entries. Power of two. RES_DEPTH >= MAC_LAT+2 is required for 1 op/cycle throughput.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand triple valid
- in_ready  out  1  block can accept operand triple
- in_fp_mode  in  2  00=FP32, 01=FP16, 10=FP16 mixed, 11=illegal
- in_rm  in  3  rounding mode
- in_a, in_b, in_c  in  32 each  operands (FP16 uses bits [15:0])
- mac_fp_mode_o  out  2  to MAC fp_mode
- mac_rm_o  out  3  to MAC rm_i
- mac_a16_o, mac_b16_o, mac_c16_o  out  16 each  to MAC A16/B16/C16
- mac_a32_o, mac_b32_o, mac_c32_o  out  32 each  to MAC A32/B32/C32
- mac_r32_i  in  32  MAC R32 result
- mac_flags_i  in  5  MAC flags {NV,OF,UF,NX,0}
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  32  result word
- out_flags  out  5  flags of this result
- out_mode  out  2  fp_mode of this result
- flags_sticky_o  out  5  OR of all captured flags since reset/clear
- flags_clr_i  in  1  clear sticky flags
- busy_o  out  1  op in flight or FIFO non-empty

Behaviour:
- Issue:
  - issue = in_valid & in_ready.
  - in_ready = !rst & (inflight_cnt + fifo_cnt < RES_DEPTH). inflight_cnt is the popcount of the tag pipe.
  - Credit is conservative: a same-cycle pop does not free credit.
- MAC drive:
  - mac_* outputs are combinational passthrough of in_* (a16=in_a[15:0], a32=in_a, etc.), regardless of in_valid.
  - The MAC samples on the issue edge. Non-issue cycles produce untagged garbage, which is ignored.
- Tag pipe:
  - MAC_LAT stages, each holding {v, mode[1:0], illegal}.
  - Stage 0 loads {issue, in_fp_mode, in_fp_mode==11} each edge; later stages shift.
  - When the last stage has v=1, the next edge writes the FIFO.
  - Result captured at edge k+MAC_LAT for an op issued at edge k.
- Capture conversion:
  - mode 00 or 10: result = mac_r32_i.
  - mode 01: result = {16'h0, fp32_to_fp16_conv(mac_r32_i)}.
  - illegal: result = 32'h7FC00000, flags = 5'b10000; MAC outputs ignored.
  - Otherwise flags = mac_flags_i.
- FIFO:
  - out_valid = !empty; out_* driven from the head entry.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop allowed; count unchanged.
  - Push while full cannot occur by construction; the bench asserts this.
  - Order is strictly preserved.
- Sticky flags:
  - On capture, flags_sticky_o |= captured flags.
  - flags_clr_i alone: cleared to 0.
  - flags_clr_i together with capture: value = captured flags only.
- busy_o = (inflight_cnt != 0) | !empty.
- Reset (any cycle, including mid-flight):
  - Tag pipe, FIFO pointers/count and sticky flags cleared.
  - out_valid=0, out_result=0, out_flags=0, out_mode=0, flags_sticky_o=0, busy_o=0, in_ready=0.
  - In-flight MAC results are discarded.
  - in_ready may assert the first cycle after rst deasserts.

Test Plan:
- FP32 single op: a=3F800000, b=40000000, c=3F000000, mode 00, issued at edge k -> out_valid rises after edge k+3, out_result=40200000, out_flags=0, out_mode=00.
- FP16 op: a=3C00, b=4000, c=3800, mode 01 -> out_result=00004100.
- Streaming: 20 ops back-to-back with out_ready=1 -> in_ready stays 1, one result per cycle after latency, order matches.
- Backpressure: out_ready=0, in_valid held -> exactly 8 accepted, then in_ready=0 with FIFO full and no overflow; release out_ready -> all 8 results drained in order, issue resumes.
- Illegal and sticky: mode 11 op -> result 7FC00000, out_flags=10000, flags_sticky_o=10000; FP32 a=7F800000, b=0, c=0 -> NV set; flags_clr_i same cycle as a clean capture -> sticky=0.
- Reset mid-flight: assert rst with 3 ops in flight and 2 in FIFO -> next cycle out_valid=0, busy_o=0, sticky=0; no stale results appear afterwards.
